// File: rtl/ls_buffer_ooo_pkg.sv
// Shared opcode encoding for the load/store buffer and its age picker.
// Loads occupy LB..LHU; every other opcode reaching the buffer is treated as a store.
package ls_buffer_ooo_pkg;

   localparam int OP_LB  = 0;
   localparam int OP_LH  = 1;
   localparam int OP_LW  = 2;
   localparam int OP_LBU = 3;
   localparam int OP_LHU = 4;
   localparam int OP_SB  = 5;
   localparam int OP_SH  = 6;
   localparam int OP_SW  = 7;

   function automatic logic is_load_op(input int op);
      return (op >= OP_LB) && (op <= OP_LHU);
   endfunction

endpackage

// File: rtl/lsb_age_picker.sv
// Oldest-first one-hot grant over a circular request vector; age is the distance from head_idx.
// DEPTH must equal 2**IDX_W so that index arithmetic wraps naturally.
module lsb_age_picker #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic [DEPTH-1:0] req,
   input  logic [IDX_W-1:0] head_idx,
   output logic [DEPTH-1:0] grant,
   output logic             any
);

   assign any = |req;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
      grant = '0;
      // Walk youngest to oldest so the oldest requester is the last one written.
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (req[head_idx + IDX_W'(k)]) begin
            grant = '0;
            grant[head_idx + IDX_W'(k)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ls_buffer_ooo.sv
// Load/store buffer between Dispatcher and LSCtrl: program-ordered ops, CDB wakeup, one issue per grant.
// Stores issue from the head when they are ROB head; with ISSUE_MODE=1 loads may pass disambiguated stores.
module ls_buffer_ooo
   import ls_buffer_ooo_pkg::*;
#(
   parameter int LSB_DEPTH   = 16,
   parameter int DATA_W      = 32,
   parameter int ROB_W       = 4,
   parameter int OP_W        = 6,
   parameter int CDB_PORTS   = 2,
   parameter int FULL_MARGIN = 2,
   parameter int ISSUE_MODE  = 1
) (
   input  logic                          clk_in,
   input  logic                          rst_n_in,
   input  logic                          rdy_in,
   input  logic                          rdy_dp_in,
   input  logic [OP_W-1:0]               opcode_dp_in,
   input  logic [ROB_W-1:0]              qj_dp_in,
   input  logic [ROB_W-1:0]              qk_dp_in,
   input  logic [DATA_W-1:0]             vj_dp_in,
   input  logic [DATA_W-1:0]             vk_dp_in,
   input  logic [DATA_W-1:0]             A_dp_in,
   input  logic [ROB_W-1:0]              rob_id_dp_in,
   output logic                          lsb_full_dp_out,
   output logic [$clog2(LSB_DEPTH):0]    count_out,
   input  logic [ROB_W-1:0]              head_id_rob_in,
   input  logic                          idle_lsc_in,
   output logic                          rdy_lsc_out,
   output logic [OP_W-1:0]               opcode_lsc_out,
   output logic [DATA_W-1:0]             vj_lsc_out,
   output logic [DATA_W-1:0]             vk_lsc_out,
   output logic [DATA_W-1:0]             imm_lsc_out,
   output logic [ROB_W-1:0]              rob_id_lsc_out,
   input  logic [CDB_PORTS-1:0]          cdb_rdy_in,
   input  logic [CDB_PORTS*ROB_W-1:0]    cdb_rob_in,
   input  logic [CDB_PORTS*DATA_W-1:0]   cdb_val_in,
   input  logic                          refresh_rob_cdb_in
);

   localparam int LSB_W = $clog2(LSB_DEPTH);
   localparam int CNT_W = LSB_W + 1;

   logic [CNT_W-1:0]     head_q, tail_q, count, head_next, tail_next;
   logic [LSB_W-1:0]     head_idx, tail_idx, issue_idx;
   logic [LSB_DEPTH-1:0] valid_q, valid_next, is_load, store_block, load_req, load_grant, issue_oh;
   logic [OP_W-1:0]      op_q  [LSB_DEPTH];
   logic [ROB_W-1:0]     qj_q  [LSB_DEPTH];
   logic [ROB_W-1:0]     qk_q  [LSB_DEPTH];
   logic [ROB_W-1:0]     rob_q [LSB_DEPTH];
   logic [DATA_W-1:0]    vj_q  [LSB_DEPTH];
   logic [DATA_W-1:0]    vk_q  [LSB_DEPTH];
   logic [DATA_W-1:0]    imm_q [LSB_DEPTH];
   logic [DATA_W-1:0]    addr  [LSB_DEPTH];
   logic [LSB_W-1:0]     age   [LSB_DEPTH];
   logic [ROB_W-1:0]     cdb_tag [CDB_PORTS];
   logic [DATA_W-1:0]    cdb_val [CDB_PORTS];
   logic [ROB_W-1:0]     dp_qj, dp_qk;
   logic [DATA_W-1:0]    dp_vj, dp_vk;
   logic                 load_any, can_issue, store_go, issue_go, dp_en, skipping;

   assign count           = tail_q - head_q;
   assign count_out       = count;
   assign head_idx        = head_q[LSB_W-1:0];
   assign tail_idx        = tail_q[LSB_W-1:0];
   assign lsb_full_dp_out = count >= CNT_W'(LSB_DEPTH - FULL_MARGIN);
   assign dp_en           = rdy_dp_in && (count != CNT_W'(LSB_DEPTH));

   // Unpack CDB ports and apply same-cycle bypass to the operands being dispatched.
   always_comb begin
      dp_qj = qj_dp_in;
      dp_vj = vj_dp_in;
      dp_qk = qk_dp_in;
      dp_vk = vk_dp_in;
      for (int p = 0; p < CDB_PORTS; p++) begin
         cdb_tag[p] = cdb_rob_in[p*ROB_W +: ROB_W];
         cdb_val[p] = cdb_val_in[p*DATA_W +: DATA_W];
         if (cdb_rdy_in[p] && qj_dp_in != '0 && qj_dp_in == cdb_tag[p]) begin
            dp_qj = '0;
            dp_vj = cdb_val[p];
         end
         if (cdb_rdy_in[p] && qk_dp_in != '0 && qk_dp_in == cdb_tag[p]) begin
            dp_qk = '0;
            dp_vk = cdb_val[p];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < LSB_DEPTH; i++) begin
         is_load[i] = is_load_op(int'(op_q[i]));
         addr[i]    = vj_q[i] + imm_q[i];
         age[i]     = LSB_W'(i) - head_idx;
      end
   end

   // A load is blocked by any older valid store whose address is unknown or shares its word.
   always_comb begin
      store_block = '0;
      load_req    = '0;
      for (int i = 0; i < LSB_DEPTH; i++) begin
         for (int j = 0; j < LSB_DEPTH; j++) begin
            if (valid_q[j] && !is_load[j] && age[j] < age[i] &&
                (qj_q[j] != '0 || (addr[j] >> 2) == (addr[i] >> 2)))
               store_block[i] = 1'b1;
         end
         if (ISSUE_MODE != 0)
            load_req[i] = valid_q[i] && is_load[i] && qj_q[i] == '0 && !store_block[i];
         else
            load_req[i] = valid_q[i] && is_load[i] && qj_q[i] == '0 && LSB_W'(i) == head_idx;
      end
   end

   lsb_age_picker #(
      .DEPTH (LSB_DEPTH),
      .IDX_W (LSB_W)
   ) u_age_picker (
      .req      (load_req),
      .head_idx (head_idx),
      .grant    (load_grant),
      .any      (load_any)
   );

   always_comb begin
      can_issue = idle_lsc_in && !rdy_lsc_out;
      store_go  = can_issue && valid_q[head_idx] && !is_load[head_idx] && qj_q[head_idx] == '0 &&
                  qk_q[head_idx] == '0 && rob_q[head_idx] == head_id_rob_in;
      issue_go  = store_go || (can_issue && load_any);
      issue_oh  = '0;
      if (store_go)
         issue_oh[head_idx] = 1'b1;
      else if (issue_go)
         issue_oh = load_grant;
      issue_idx = '0;
      for (int i = 0; i < LSB_DEPTH; i++)
         if (issue_oh[i]) issue_idx = issue_idx | LSB_W'(i);

      valid_next = valid_q & ~issue_oh;
      if (dp_en) valid_next[tail_idx] = 1'b1;
      tail_next = tail_q + CNT_W'(dp_en);

      // NOTE: blocking '=' chains on purpose: each step tests the slot the previous step advanced to.
      head_next = head_q;
      skipping  = 1'b1;
      for (int k = 0; k < LSB_DEPTH; k++) begin
         if (skipping && head_next != tail_next && !valid_next[head_next[LSB_W-1:0]])
            head_next = head_next + CNT_W'(1);
         else
            skipping = 1'b0;
      end
   end

   // NOTE: flops use non-blocking '<=' so every register samples the pre-edge state.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         head_q         <= '0;
         tail_q         <= '0;
         valid_q        <= '0;
         rdy_lsc_out    <= 1'b0;
         opcode_lsc_out <= '0;
         vj_lsc_out     <= '0;
         vk_lsc_out     <= '0;
         imm_lsc_out    <= '0;
         rob_id_lsc_out <= '0;
      end else if (!rdy_in) begin
         rdy_lsc_out <= 1'b0;
      end else if (refresh_rob_cdb_in) begin
         head_q      <= '0;
         tail_q      <= '0;
         valid_q     <= '0;
         rdy_lsc_out <= 1'b0;
      end else begin
         head_q      <= head_next;
         tail_q      <= tail_next;
         valid_q     <= valid_next;
         rdy_lsc_out <= issue_go;
         if (issue_go) begin
            opcode_lsc_out <= op_q[issue_idx];
            vj_lsc_out     <= vj_q[issue_idx];
            vk_lsc_out     <= vk_q[issue_idx];
            imm_lsc_out    <= imm_q[issue_idx];
            rob_id_lsc_out <= rob_q[issue_idx];
         end
      end
   end

   // NOTE: the payload array has no reset; valid_q alone decides whether a slot holds anything meaningful.
   always_ff @(posedge clk_in) begin
      if (rdy_in && !refresh_rob_cdb_in) begin
         for (int i = 0; i < LSB_DEPTH; i++) begin
            for (int p = 0; p < CDB_PORTS; p++) begin
               if (cdb_rdy_in[p] && qj_q[i] != '0 && qj_q[i] == cdb_tag[p]) begin
                  qj_q[i] <= '0;
                  vj_q[i] <= cdb_val[p];
               end
               if (cdb_rdy_in[p] && qk_q[i] != '0 && qk_q[i] == cdb_tag[p]) begin
                  qk_q[i] <= '0;
                  vk_q[i] <= cdb_val[p];
               end
            end
         end
         if (dp_en) begin
            op_q[tail_idx]  <= opcode_dp_in;
            qj_q[tail_idx]  <= dp_qj;
            vj_q[tail_idx]  <= dp_vj;
            qk_q[tail_idx]  <= dp_qk;
            vk_q[tail_idx]  <= dp_vk;
            imm_q[tail_idx] <= A_dp_in;
            rob_q[tail_idx] <= rob_id_dp_in;
         end
      end
   end

   dispatch_into_full_a : assert property (@(posedge clk_in) disable iff (!rst_n_in)
      !(rdy_in && !refresh_rob_cdb_in && rdy_dp_in && count == CNT_W'(LSB_DEPTH)));

endmodule

// File: tb/tb_ls_buffer_ooo.sv
// Self-checking bench for ls_buffer_ooo: directed scenarios plus random traffic against a queue model.
module tb_ls_buffer_ooo;
   import ls_buffer_ooo_pkg::*;

   localparam int DEPTH  = 16;
   localparam int DW     = 32;
   localparam int RW     = 4;
   localparam int OW     = 6;
   localparam int NP     = 2;
   localparam int MARGIN = 2;

   logic           clk_in, rst_n_in, rdy_in, rdy_dp_in;
   logic [OW-1:0]  opcode_dp_in;
   logic [RW-1:0]  qj_dp_in, qk_dp_in, rob_id_dp_in, head_id_rob_in;
   logic [DW-1:0]  vj_dp_in, vk_dp_in, A_dp_in;
   logic           lsb_full_dp_out, idle_lsc_in, rdy_lsc_out, refresh_rob_cdb_in;
   logic [4:0]     count_out;
   logic [OW-1:0]  opcode_lsc_out;
   logic [DW-1:0]  vj_lsc_out, vk_lsc_out, imm_lsc_out;
   logic [RW-1:0]  rob_id_lsc_out;
   logic [NP-1:0]  cdb_rdy_in;
   logic [NP*RW-1:0] cdb_rob_in;
   logic [NP*DW-1:0] cdb_val_in;

   ls_buffer_ooo dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rdy_dp_in(rdy_dp_in),
      .opcode_dp_in(opcode_dp_in), .qj_dp_in(qj_dp_in), .qk_dp_in(qk_dp_in),
      .vj_dp_in(vj_dp_in), .vk_dp_in(vk_dp_in), .A_dp_in(A_dp_in), .rob_id_dp_in(rob_id_dp_in),
      .lsb_full_dp_out(lsb_full_dp_out), .count_out(count_out), .head_id_rob_in(head_id_rob_in),
      .idle_lsc_in(idle_lsc_in), .rdy_lsc_out(rdy_lsc_out), .opcode_lsc_out(opcode_lsc_out),
      .vj_lsc_out(vj_lsc_out), .vk_lsc_out(vk_lsc_out), .imm_lsc_out(imm_lsc_out),
      .rob_id_lsc_out(rob_id_lsc_out), .cdb_rdy_in(cdb_rdy_in), .cdb_rob_in(cdb_rob_in),
      .cdb_val_in(cdb_val_in), .refresh_rob_cdb_in(refresh_rob_cdb_in)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [OW-1:0] op;
      logic [RW-1:0] qj, qk, rob;
      logic [DW-1:0] vj, vk, imm;
      bit            valid;
   } ent_t;

   ent_t          mq[$];
   logic          m_rdy;
   logic [OW-1:0] m_op;
   logic [DW-1:0] m_vj, m_vk, m_imm;
   logic [RW-1:0] m_rob;
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_is_load(input logic [OW-1:0] op);
      return op <= OW'(OP_LHU);
   endfunction

   function automatic ent_t wake(input ent_t e_in);
      ent_t e = e_in;
      for (int p = 0; p < NP; p++) begin
         if (cdb_rdy_in[p]) begin
            if (e.qj != 0 && e.qj == cdb_rob_in[p*RW +: RW]) begin
               e.qj = '0;
               e.vj = cdb_val_in[p*DW +: DW];
            end
            if (e.qk != 0 && e.qk == cdb_rob_in[p*RW +: RW]) begin
               e.qk = '0;
               e.vk = cdb_val_in[p*DW +: DW];
            end
         end
      end
      return e;
   endfunction

   // Load i may go only if every older live store has a known address in a different word.
   function automatic bit older_ok(input int i);
      logic [DW-1:0] a_i, a_j;
      a_i = mq[i].vj + mq[i].imm;
      for (int j = 0; j < i; j++) begin
         a_j = mq[j].vj + mq[j].imm;
         if (mq[j].valid && !m_is_load(mq[j].op) && (mq[j].qj != 0 || a_j / 4 == a_i / 4))
            return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_rdy = 1'b0; m_op = '0; m_vj = '0; m_vk = '0; m_imm = '0; m_rob = '0;
   endtask

   task automatic model_step();
      int   pick;
      bit   can;
      ent_t e;
      if (!rdy_in) begin
         m_rdy = 1'b0;
         return;
      end
      if (refresh_rob_cdb_in) begin
         mq.delete();
         m_rdy = 1'b0;
         return;
      end
      can  = idle_lsc_in && !m_rdy;
      pick = -1;
      if (can && mq.size() > 0) begin
         e = mq[0];
         if (!m_is_load(e.op) && e.qj == 0 && e.qk == 0 && e.rob == head_id_rob_in)
            pick = 0;
         else
            for (int i = 0; i < mq.size(); i++)
               if (pick < 0 && mq[i].valid && m_is_load(mq[i].op) && mq[i].qj == 0 && older_ok(i))
                  pick = i;
      end
      m_rdy = (pick >= 0);
      if (pick >= 0) begin
         e = mq[pick];
         m_op = e.op; m_vj = e.vj; m_vk = e.vk; m_imm = e.imm; m_rob = e.rob;
         e.valid = 1'b0;
         mq[pick] = e;
      end
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
      if (rdy_dp_in && mq.size() < DEPTH) begin
         e.op = opcode_dp_in; e.qj = qj_dp_in; e.qk = qk_dp_in; e.vj = vj_dp_in;
         e.vk = vk_dp_in; e.imm = A_dp_in; e.rob = rob_id_dp_in; e.valid = 1'b1;
         mq.push_back(wake(e));
      end
      while (mq.size() > 0 && !mq[0].valid) void'(mq.pop_front());
   endtask

   task automatic compare(input string tag);
      check({tag, "/count"}, 64'(count_out), 64'(mq.size()));
      check({tag, "/full"}, 64'(lsb_full_dp_out), 64'(mq.size() >= DEPTH - MARGIN));
      check({tag, "/rdy"}, 64'(rdy_lsc_out), 64'(m_rdy));
      if (m_rdy) begin
         check({tag, "/op"}, 64'(opcode_lsc_out), 64'(m_op));
         check({tag, "/vj"}, 64'(vj_lsc_out), 64'(m_vj));
         check({tag, "/vk"}, 64'(vk_lsc_out), 64'(m_vk));
         check({tag, "/imm"}, 64'(imm_lsc_out), 64'(m_imm));
         check({tag, "/rob"}, 64'(rob_id_lsc_out), 64'(m_rob));
      end
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk_in);
      #1;
      compare(tag);
   endtask

   task automatic clr_in();
      rdy_dp_in = 1'b0; refresh_rob_cdb_in = 1'b0; opcode_dp_in = '0;
      qj_dp_in = '0; qk_dp_in = '0; vj_dp_in = '0; vk_dp_in = '0; A_dp_in = '0; rob_id_dp_in = '0;
      cdb_rdy_in = '0; cdb_rob_in = '0; cdb_val_in = '0;
   endtask

   task automatic set_dp(input int op, input logic [RW-1:0] qj, input logic [DW-1:0] vj,
                         input logic [RW-1:0] qk, input logic [DW-1:0] vk,
                         input logic [DW-1:0] imm, input logic [RW-1:0] rob);
      rdy_dp_in = 1'b1; opcode_dp_in = OW'(op); qj_dp_in = qj; vj_dp_in = vj;
      qk_dp_in = qk; vk_dp_in = vk; A_dp_in = imm; rob_id_dp_in = rob;
   endtask

   task automatic set_cdb(input int p, input logic [RW-1:0] tag, input logic [DW-1:0] val);
      cdb_rdy_in[p] = 1'b1;
      cdb_rob_in[p*RW +: RW] = tag;
      cdb_val_in[p*DW +: DW] = val;
   endtask

   task automatic flush();
      clr_in();
      refresh_rob_cdb_in = 1'b1;
      tick("flush");
      refresh_rob_cdb_in = 1'b0;
   endtask

   initial begin
      logic [RW-1:0] t0, t1;
      rst_n_in = 1'b0; rdy_in = 1'b1; idle_lsc_in = 1'b0; head_id_rob_in = '0;
      clr_in();
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      compare("reset");
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // Asynchronous reset with three entries resident.
      for (int i = 0; i < 3; i++) begin
         set_dp(OP_SW, '0, 32'h40 + DW'(i * 4), '0, DW'(i), '0, RW'(i + 1));
         tick("rst_fill");
      end
      clr_in();
      check("pre_rst_count", 64'(count_out), 64'd3);
      #2 rst_n_in = 1'b0;
      #1;
      check("async_rst_count", 64'(count_out), 64'd0);
      check("async_rst_rdy", 64'(rdy_lsc_out), 64'd0);
      model_reset();
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // Fill to the full threshold, then drain one.
      for (int i = 0; i < 14; i++) begin
         set_dp(OP_SW, '0, 32'h100 + DW'(i * 4), '0, DW'(i), '0, RW'(i % 15 + 1));
         tick("fill");
      end
      clr_in();
      check("fill_full", 64'(lsb_full_dp_out), 64'd1);
      idle_lsc_in = 1'b1; head_id_rob_in = 4'd1;
      tick("fill_issue");
      check("fill_pulse", 64'(rdy_lsc_out), 64'd1);
      check("fill_unfull", 64'(lsb_full_dp_out), 64'd0);
      flush();

      // Dispatch-cycle CDB bypass.
      set_dp(OP_LW, 4'd5, '0, '0, '0, '0, 4'd2);
      set_cdb(1, 4'd5, 32'h1234);
      tick("bypass_dp");
      clr_in();
      tick("bypass_issue");
      check("bypass_vj", 64'(vj_lsc_out), 64'h1234);

      // Store waits for ROB head.
      head_id_rob_in = 4'd2;
      set_dp(OP_SW, '0, 32'h300, '0, 32'hBEEF, '0, 4'd3);
      tick("gate_dp");
      clr_in();
      tick("gate_wait");
      tick("gate_wait");
      check("gate_hold", 64'(rdy_lsc_out), 64'd0);
      head_id_rob_in = 4'd3;
      tick("gate_go");
      check("gate_rob", 64'(rob_id_lsc_out), 64'd3);
      flush();

      // Out-of-order load issue past a resolved, non-aliasing store; aliasing load waits.
      head_id_rob_in = 4'd9;
      set_dp(OP_SW, 4'd7, '0, '0, 32'hAA, '0, 4'd4);
      tick("m1_st");
      set_dp(OP_LW, '0, 32'h200, '0, '0, '0, 4'd5);
      tick("m1_ld");
      clr_in();
      tick("m1_wait");
      tick("m1_wait");
      check("m1_unresolved_hold", 64'(rdy_lsc_out), 64'd0);
      set_cdb(0, 4'd7, 32'h100);
      tick("m1_resolve");
      clr_in();
      tick("m1_ld_go");
      check("m1_ld_rob", 64'(rob_id_lsc_out), 64'd5);
      set_dp(OP_LW, '0, 32'h100, '0, '0, 32'd2, 4'd6);
      tick("m1_alias_dp");
      clr_in();
      tick("m1_alias_wait");
      tick("m1_alias_wait");
      check("m1_alias_hold", 64'(rdy_lsc_out), 64'd0);
      head_id_rob_in = 4'd4;
      tick("m1_st_go");
      check("m1_st_rob", 64'(rob_id_lsc_out), 64'd4);
      tick("m1_gap");
      tick("m1_alias_go");
      check("m1_alias_rob", 64'(rob_id_lsc_out), 64'd6);
      flush();

      // In-order store stream across the pointer wrap.
      idle_lsc_in = 1'b1;
      for (int c = 0; c < 40; c++) begin
         clr_in();
         if (mq.size() > 0) head_id_rob_in = mq[0].rob;
         if (mq.size() < DEPTH - MARGIN)
            set_dp(OP_SB + c % 3, '0, 32'h500 + DW'(c), '0, DW'(c), DW'(c % 4), RW'(c % 15 + 1));
         tick("wrap");
      end
      flush();

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         clr_in();
         rdy_in             = ($urandom_range(0, 15) != 0);
         refresh_rob_cdb_in = ($urandom_range(0, 79) == 0);
         idle_lsc_in        = ($urandom_range(0, 3) != 0);
         if (mq.size() > 0 && $urandom_range(0, 1) == 1) head_id_rob_in = mq[0].rob;
         else head_id_rob_in = RW'($urandom_range(1, 15));
         if (mq.size() < DEPTH - MARGIN && $urandom_range(0, 2) != 0)
            set_dp(int'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) == 1) ? RW'($urandom_range(1, 15)) : RW'(0),
                   32'h100 + DW'($urandom_range(0, 31)),
                   ($urandom_range(0, 2) == 0) ? RW'($urandom_range(1, 15)) : RW'(0),
                   DW'($urandom), DW'($urandom_range(0, 7)), RW'($urandom_range(1, 15)));
         t0 = RW'($urandom_range(1, 15));
         t1 = RW'((int'(t0) + int'($urandom_range(0, 13))) % 15 + 1);
         if ($urandom_range(0, 1) == 1) set_cdb(0, t0, 32'h100 + DW'($urandom_range(0, 31)));
         if ($urandom_range(0, 1) == 1) set_cdb(1, t1, 32'h100 + DW'($urandom_range(0, 31)));
         tick("rand");
      end

      // Flush with five resident entries and an issue pending.
      clr_in();
      rdy_in = 1'b1;
      idle_lsc_in = 1'b0;
      flush();
      for (int i = 0; i < 5; i++) begin
         set_dp(OP_LW, '0, 32'h600 + DW'(i * 4), '0, '0, '0, RW'(i + 1));
         tick("fl5_fill");
      end
      clr_in();
      check("fl5_count", 64'(count_out), 64'd5);
      idle_lsc_in = 1'b1;
      flush();
      check("fl5_empty", 64'(count_out), 64'd0);
      check("fl5_nopulse", 64'(rdy_lsc_out), 64'd0);
      tick("fl5_after");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
